// File: rtl/dgldpc_vnu_pipe.sv
// Pipelined variable-node unit: 3 enabled cycles input to output, only i_en stalls it.
// Defining DGLDPC_VNU_SATCNT_EN adds the o_sat_cnt saturation-event counter port.
module dgldpc_vnu_pipe #(
   parameter int DV    = 4,
   parameter int MSG_W = 6,
   parameter int LLR_W = 9,
   parameter int OUT_W = 10,
   localparam int SUM_W = ((LLR_W > MSG_W) ? LLR_W : MSG_W) + $clog2(DV + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_en,
   input  logic                          i_valid,
   input  logic [LLR_W-1:0]              i_llr,
   input  logic [DV-1:0][MSG_W-1:0]      i_data,
   output logic                          o_valid,
   output logic [DV-1:0][OUT_W-1:0]      o_data,
   output logic [SUM_W-1:0]              o_app,
`ifdef DGLDPC_VNU_SATCNT_EN
   output logic                          o_hard,
   output logic [15:0]                   o_sat_cnt
`else
   output logic                          o_hard
`endif
);

   localparam int EXT_W = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
   localparam logic signed [EXT_W-1:0] LIM = (EXT_W'(1) <<< (OUT_W - 1)) - EXT_W'(1);
   localparam logic [OUT_W-2:0] MAG_MAX = '1;

   // Negative zero falls out as 0 because -0 == 0.
   function automatic logic signed [SUM_W-1:0] sm_to_tc(input logic [SUM_W-1:0] mag, input logic sgn);
      return sgn ? -$signed(mag) : $signed(mag);
   endfunction

   logic                    s1_vld, s2_vld;
   logic signed [SUM_W-1:0] s1_llr;
   logic signed [SUM_W-1:0] s1_msg [DV];
   logic signed [SUM_W-1:0] s2_msg [DV];
   logic signed [SUM_W-1:0] s2_app;
   logic signed [SUM_W-1:0] app_sum;
   logic [DV-1:0][OUT_W-1:0] ext_sm;
   logic                    any_sat;

   always_comb begin
      app_sum = s1_llr;
      for (int i = 0; i < DV; i++) app_sum = app_sum + s1_msg[i];
   end

   always_comb begin
      ext_sm  = '0;
      any_sat = 1'b0;
      for (int i = 0; i < DV; i++) begin
         logic signed [EXT_W-1:0] d;
         logic signed [EXT_W-1:0] nd;
         d  = EXT_W'(s2_app) - EXT_W'(s2_msg[i]);
         nd = -d;
         if (d > LIM) begin
            ext_sm[i] = {1'b0, MAG_MAX};
            any_sat   = 1'b1;
         end else if (d < -LIM) begin
            ext_sm[i] = {1'b1, MAG_MAX};
            any_sat   = 1'b1;
         end else if (d < 0) begin
            ext_sm[i] = {1'b1, nd[OUT_W-2:0]};
         end else begin
            ext_sm[i] = {1'b0, d[OUT_W-2:0]};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld  <= 1'b0;
         s1_llr  <= '0;
         s2_vld  <= 1'b0;
         s2_app  <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_app   <= '0;
         o_hard  <= 1'b0;
         for (int i = 0; i < DV; i++) begin
            s1_msg[i] <= '0;
            s2_msg[i] <= '0;
         end
      end else if (i_en) begin
         s1_vld  <= i_valid;
         s1_llr  <= sm_to_tc(SUM_W'(i_llr[LLR_W-2:0]), i_llr[LLR_W-1]);
         for (int i = 0; i < DV; i++) begin
            s1_msg[i] <= sm_to_tc(SUM_W'(i_data[i][MSG_W-2:0]), i_data[i][MSG_W-1]);
            s2_msg[i] <= s1_msg[i];
         end
         s2_vld  <= s1_vld;
         s2_app  <= app_sum;
         o_valid <= s2_vld;
         o_data  <= ext_sm;
         o_app   <= s2_app;
         o_hard  <= s2_app[SUM_W-1];
      end
   end

`ifdef DGLDPC_VNU_SATCNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         o_sat_cnt <= '0;
      else if (i_en && s2_vld && any_sat && (o_sat_cnt != 16'hFFFF))
         o_sat_cnt <= o_sat_cnt + 16'd1;
   end
`endif

endmodule
